// File: rtl/decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_pkg                                                   |
// | Description : Opcodes, ALU encodings and decode types for decode_cycle.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package decode_pkg;

    localparam logic [6:0] C_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] C_OP_IALU  = 7'b0010011;
    localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] C_OP_STORE = 7'b0100011;
    localparam logic [6:0] C_OP_BEQ   = 7'b1100011;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_S    = 2'd2,
        IMM_B    = 2'd3
    } imm_type_e;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic       result_src;
        logic       branch;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } idex_t;

    // sub_en is only ever set for R-type; I-type funct7 bits are immediate data.
    function automatic logic [2:0] alu_op(input logic [2:0] funct3, input logic sub_en);
        case (funct3)
            3'b000:  alu_op = sub_en ? C_ALU_SUB : C_ALU_ADD;
            3'b010:  alu_op = C_ALU_SLT;
            3'b110:  alu_op = C_ALU_OR;
            3'b111:  alu_op = C_ALU_AND;
            default: alu_op = C_ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register_file                                                |
// | Description : 32x32 register file, 2 async read ports, 1 write port, x0=0. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module register_file #(
    parameter bit BYPASS_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];
    logic        w_wr_en;

    assign w_wr_en = we_i && (wa_i != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    generate
        if (BYPASS_EN) begin : g_bypass
            assign rd1_o = (ra1_i == 5'd0) ? 32'd0 :
                           (w_wr_en && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
            assign rd2_o = (ra2_i == 5'd0) ? 32'd0 :
                           (w_wr_en && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
        end else begin : g_no_bypass
            assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
            assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : decode_cycle                                                 |
// | Description : RV32I-subset decode stage with register file and ID/EX regs. |
// |               Define REGFILE_WR_BYPASS_EN to forward same-cycle writeback. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module decode_cycle
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        ALUSrcE,
    output logic        MemWriteE,
    output logic        ResultSrcE,
    output logic        BranchE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1_E,
    output logic [31:0] RD2_E,
    output logic [31:0] Imm_Ext_E,
    output logic [4:0]  RD_E,
    output logic [4:0]  RS1_E,
    output logic [4:0]  RS2_E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E
);

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit C_BYPASS_EN = 1'b1;
`else
    localparam bit C_BYPASS_EN = 1'b0;
`endif

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_imm;
    ctrl_t       w_ctrl;
    imm_type_e   w_imm_type;
    idex_t       idex_d;
    idex_t       idex_q;

    assign w_opcode = InstrD[6:0];
    assign w_rd     = InstrD[11:7];
    assign w_funct3 = InstrD[14:12];
    assign w_rs1    = InstrD[19:15];
    assign w_rs2    = InstrD[24:20];

    register_file #(
        .BYPASS_EN (C_BYPASS_EN)
    ) u_register_file (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (w_rs1),
        .ra2_i (w_rs2),
        .rd1_o (w_rd1),
        .rd2_o (w_rd2),
        .we_i  (RegWriteW),
        .wa_i  (RDW),
        .wd_i  (ResultW)
    );

    always_comb begin
        w_ctrl     = '0;
        w_imm_type = IMM_NONE;
        case (w_opcode)
            C_OP_RTYPE: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_ctrl  = alu_op(w_funct3, InstrD[30]);
            end
            C_OP_IALU: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_ctrl  = alu_op(w_funct3, 1'b0);
                w_imm_type       = IMM_I;
            end
            C_OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.result_src = 1'b1;
                w_ctrl.alu_ctrl   = C_ALU_ADD;
                w_imm_type        = IMM_I;
            end
            C_OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.alu_ctrl  = C_ALU_ADD;
                w_imm_type       = IMM_S;
            end
            C_OP_BEQ: begin
                w_ctrl.branch   = 1'b1;
                w_ctrl.alu_ctrl = C_ALU_SUB;
                w_imm_type      = IMM_B;
            end
            default: begin
                w_ctrl     = '0;
                w_imm_type = IMM_NONE;
            end
        endcase
    end

    always_comb begin
        w_imm = '0;
        case (w_imm_type)
            IMM_I:   w_imm = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   w_imm = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   w_imm = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                              InstrD[30:25], InstrD[11:8], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // A flush squashes controls and register tags; data fields are don't-care.
    always_comb begin
        idex_d          = '0;
        idex_d.ctrl     = FlushE ? '0 : w_ctrl;
        idex_d.rd1      = w_rd1;
        idex_d.rd2      = w_rd2;
        idex_d.imm      = w_imm;
        idex_d.rd       = FlushE ? 5'd0 : w_rd;
        idex_d.rs1      = FlushE ? 5'd0 : w_rs1;
        idex_d.rs2      = FlushE ? 5'd0 : w_rs2;
        idex_d.pc       = PCD;
        idex_d.pc_plus4 = PCPlus4D;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.ctrl.reg_write;
    assign ALUSrcE     = idex_q.ctrl.alu_src;
    assign MemWriteE   = idex_q.ctrl.mem_write;
    assign ResultSrcE  = idex_q.ctrl.result_src;
    assign BranchE     = idex_q.ctrl.branch;
    assign ALUControlE = idex_q.ctrl.alu_ctrl;
    assign RD1_E       = idex_q.rd1;
    assign RD2_E       = idex_q.rd2;
    assign Imm_Ext_E   = idex_q.imm;
    assign RD_E        = idex_q.rd;
    assign RS1_E       = idex_q.rs1;
    assign RS2_E       = idex_q.rs2;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_decode_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_decode_cycle                                              |
// | Description : Self-checking bench for decode_cycle (REGFILE_WR_BYPASS_EN). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E, RS1_E, RS2_E;

    always #5 clk = ~clk;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_regs [32];
    logic        e_rw, e_src, e_mw, e_res, e_br;
    logic [2:0]  e_alu;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
    logic [4:0]  e_rd, e_rs1, e_rs2;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_WR_BYPASS_EN
        if (RegWriteW && RDW == a) return ResultW;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [2:0] model_alu(input logic [2:0] f3, input logic sub);
        if (f3 == 3'd0) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    // Expected ID/EX contents for the current inputs and pre-edge register state.
    task automatic predict();
        logic [31:0] ins;
        int          off;
        ins = InstrD;
        {e_rw, e_src, e_mw, e_res, e_br} = 5'b0;
        e_alu = 3'd0;
        e_imm = 32'd0;
        case (ins[6:0])
            7'b0110011: begin e_rw = 1; e_alu = model_alu(ins[14:12], ins[30]); end
            7'b0010011: begin e_rw = 1; e_src = 1; e_alu = model_alu(ins[14:12], 1'b0);
                              e_imm = $signed(ins) >>> 20; end
            7'b0000011: begin e_rw = 1; e_src = 1; e_res = 1; e_imm = $signed(ins) >>> 20; end
            7'b0100011: begin e_mw = 1; e_src = 1;
                              e_imm = $signed({ins[31:25], ins[11:7], 20'd0}) >>> 20; end
            7'b1100011: begin
                e_br = 1; e_alu = 3'b001;
                off = int'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
                if (ins[31]) off = off - 8192;
                e_imm = off;
            end
            default: ;
        endcase
        e_rd1 = model_read(ins[19:15]);
        e_rd2 = model_read(ins[24:20]);
        e_rd  = ins[11:7];
        e_rs1 = ins[19:15];
        e_rs2 = ins[24:20];
        e_pc  = PCD;
        e_pc4 = PCPlus4D;
        if (FlushE) begin
            {e_rw, e_src, e_mw, e_res, e_br} = 5'b0;
            e_alu = 3'd0;
            e_rd  = 5'd0;
            e_rs1 = 5'd0;
            e_rs2 = 5'd0;
        end
    endtask

    task automatic expect_zero();
        {e_rw, e_src, e_mw, e_res, e_br} = 5'b0;
        e_alu = 0; e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_pc = 0; e_pc4 = 0;
        e_rd = 0; e_rs1 = 0; e_rs2 = 0;
    endtask

    task automatic check_outputs();
        check("RegWriteE", RegWriteE, e_rw);
        check("ALUSrcE", ALUSrcE, e_src);
        check("MemWriteE", MemWriteE, e_mw);
        check("ResultSrcE", ResultSrcE, e_res);
        check("BranchE", BranchE, e_br);
        check("ALUControlE", ALUControlE, e_alu);
        check("RD1_E", RD1_E, e_rd1);
        check("RD2_E", RD2_E, e_rd2);
        check("Imm_Ext_E", Imm_Ext_E, e_imm);
        check("RD_E", RD_E, e_rd);
        check("RS1_E", RS1_E, e_rs1);
        check("RS2_E", RS2_E, e_rs2);
        check("PCE", PCE, e_pc);
        check("PCPlus4E", PCPlus4E, e_pc4);
    endtask

    // Inputs are set before calling; outputs are compared on the following negedge.
    task automatic step();
        predict();
        @(posedge clk);
        if (RegWriteW && RDW != 5'd0) m_regs[RDW] = ResultW;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_in(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic fl);
        InstrD = ins; RegWriteW = we; RDW = wa; ResultW = wd; FlushE = fl;
        PCD = $urandom(); PCPlus4D = PCD + 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  op;
        logic [2:0]  f3;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: op = 7'b1100011;
            default: op = r[6:0];
        endcase
        case ($urandom_range(0, 4))
            0: f3 = 3'd0;
            1: f3 = 3'd2;
            2: f3 = 3'd6;
            3: f3 = 3'd7;
            default: f3 = r[14:12];
        endcase
        return {r[31:25], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3, r[11:7], op};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        rst = 1'b1;
        set_in(32'h00500093, 1'b0, 5'd0, 32'd0, 1'b0);
        #1 rst = 1'b0;
        #1;
        expect_zero();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();

        rst = 1'b1;
        step();
        check("rst_rel_RegWriteE", RegWriteE, 1);
        check("rst_rel_ALUSrcE", ALUSrcE, 1);
        check("rst_rel_Imm", Imm_Ext_E, 32'd5);
        check("rst_rel_RD_E", RD_E, 5'd1);

        set_in(32'h00000000, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        step();
        set_in(32'h00018133, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        check("wb_RD1_E", RD1_E, 32'hDEADBEEF);
        check("wb_ALUControlE", ALUControlE, 3'b000);

        set_in(32'h00000013, 1'b1, 5'd0, 32'h00001234, 1'b0);
        step();
        set_in(32'h00000013, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        check("x0_RD1_E", RD1_E, 32'd0);

        set_in(32'h00000000, 1'b1, 5'd5, 32'h11111111, 1'b0);
        step();
        set_in(32'h00028313, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b0);
        step();
`ifdef REGFILE_WR_BYPASS_EN
        check("bypass_RD1_E", RD1_E, 32'hA5A5A5A5);
`else
        check("bypass_RD1_E", RD1_E, 32'h11111111);
`endif
        set_in(32'h00028313, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        check("after_write_RD1_E", RD1_E, 32'hA5A5A5A5);

        set_in(32'h0020A223, 1'b0, 5'd0, 32'd0, 1'b1);
        step();
        check("flush_MemWriteE", MemWriteE, 0);
        check("flush_RegWriteE", RegWriteE, 0);
        check("flush_RD_E", RD_E, 0);
        set_in(32'h0020A223, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        check("noflush_MemWriteE", MemWriteE, 1);

        set_in(32'hFE208EE3, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        check("beq_BranchE", BranchE, 1);
        check("beq_ALUControlE", ALUControlE, 3'b001);
        check("beq_Imm", Imm_Ext_E, 32'hFFFFFFFC);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                // Asynchronous reset mid-stream with a writeback pending.
                set_in(rand_instr(), 1'b1, 5'd4, 32'hCAFEF00D, 1'b0);
                rst = 1'b0;
                #1;
                for (int k = 0; k < 32; k++) m_regs[k] = 32'd0;
                expect_zero();
                check_outputs();
                @(posedge clk);
                @(negedge clk);
                check_outputs();
                rst = 1'b1;
            end
            set_in(rand_instr(), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                   $urandom(), $urandom_range(0, 7) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have ports: clk input 1, pipeline clock, all state updates on its rising edge.
REQ-002 SHALL have port rst input 1, asynchronous active-low reset.
REQ-003 SHALL have inputs InstrD 32, PCD 32, PCPlus4D 32: instruction, its PC and PC+4 from the fetch stage.
REQ-004 SHALL have inputs RegWriteW 1, RDW 5, ResultW 32: writeback enable, destination and data.
REQ-005 SHALL have input FlushE 1: when high, the next ID/EX load is a bubble.
REQ-006 SHALL have outputs RegWriteE 1, ALUSrcE 1, MemWriteE 1, ResultSrcE 1, BranchE 1, ALUControlE 3.
REQ-007 SHALL have outputs RD1_E 32, RD2_E 32, Imm_Ext_E 32, RD_E 5, RS1_E 5, RS2_E 5, PCE 32, PCPlus4E 32.

Function
REQ-008 SHALL decode RV32I subset by opcode: R-type 0110011, I-ALU 0010011, lw 0000011, sw 0100011, beq 1100011.
REQ-009 SHALL drive all controls to 0 for any other opcode (no-op, never writes).
REQ-010 SHALL select ALUControl: add 000, sub 001, and 010, or 011, slt 101; lw/sw add, beq sub, R-type sub when funct7[5]=1 and funct3=000.
REQ-011 SHALL sign-extend immediates: I = Instr[31:20], S = {Instr[31:25],Instr[11:7]}, B = {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}.
REQ-012 SHALL read rs1=Instr[19:15], rs2=Instr[24:20] combinationally from a 32x32 register file.
REQ-013 SHALL write ResultW to register RDW on rising clk when RegWriteW=1 and RDW!=0.
REQ-014 SHALL return 0 for any read of x0; writes to x0 are discarded.
REQ-015 SHALL register all decoded values into ID/EX on each rising clk: latency exactly one cycle from InstrD to *_E outputs.
REQ-016 SHALL, when FlushE=1 at a rising edge, load all ID/EX controls and RD_E/RS1_E/RS2_E with 0; data fields may load normally.
REQ-017 SHALL treat a simultaneous write and read of the same register per the Configuration section.

Reset
REQ-018 SHALL, while rst=0, hold every ID/EX register and every output at 0 regardless of clk.
REQ-019 SHALL clear all 32 register-file entries to 0 on rst=0.
REQ-020 SHALL, on reset assertion mid-operation, discard the in-flight decode and any same-cycle writeback.
REQ-021 SHALL resume normal loading on the first rising clk after rst returns to 1.

Configuration
REQ-022 SHALL support macro REGFILE_WR_BYPASS_EN.
REQ-023 SHALL, with REGFILE_WR_BYPASS_EN defined, forward ResultW to RD1/RD2 when RegWriteW=1, RDW!=0 and RDW matches rs1/rs2 in the same cycle.
REQ-024 SHALL, without it, return the pre-write register value in that cycle; the new value is visible the following cycle.

Structure
REQ-025 SHALL place opcode constants, ALUControl encodings and an immediate-type enum in shared package decode_pkg.
REQ-026 SHALL instantiate one sub-module register_file (clk, rst, two read ports, one write port, bypass option).
REQ-027 SHALL keep control decode and immediate extension as combinational logic inside decode_cycle.

Verification
REQ-028 Reset: rst=0 with InstrD=0x00500093 -> all outputs 0; after release and one edge, RegWriteE=1, ALUSrcE=1, Imm_Ext_E=5, RD_E=1.
REQ-029 Writeback: RegWriteW=1, RDW=3, ResultW=0xDEADBEEF, then InstrD=0x00018133 -> RD1_E=0xDEADBEEF, ALUControlE=000.
REQ-030 x0: write 0x1234 to RDW=0, then read rs1=0 -> RD1_E=0.
REQ-031 Bypass: same-cycle write x5=0xA5A5A5A5 and read rs1=5 -> RD1_E=0xA5A5A5A5 with macro, previous value without.
REQ-032 Flush: InstrD=sw 0x0020A223 with FlushE=1 -> MemWriteE=0, RegWriteE=0, RD_E=0.
REQ-033 Branch: InstrD=0xFE208EE3 (beq, offset -4) -> BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFFC.
